// File: rtl/nibble_serial_adder.sv
// ============================================================================
//  Module   : nibble_serial_adder
//  Brief    : Multi-cycle WIDTH-bit adder/subtractor, one 4-bit slice per clock,
//             LSB slice first, carry rippled through a register. Exports
//             active-low group generate/propagate like the lookahead unit.
//             Optional early termination: define NIBBLE_SERIAL_EARLY_DONE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_serial_adder #(
    parameter int WIDTH  = 16,
    parameter int SLICES = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             pg_n,
    output logic             gg_n
);

    localparam int IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(SLICES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_pacc;
    logic             r_gacc;
    logic             r_pg_n;
    logic             r_gg_n;

    logic [IDX_W+1:0] w_base;
    logic [3:0]       w_sa;
    logic [3:0]       w_sb;
    logic [4:0]       w_ssum;
    logic [3:0]       w_g;
    logic [3:0]       w_p;
    logic             w_sg;
    logic             w_sp;
    logic             w_c_msb;
    logic             w_last;
    logic             w_early;
    logic             w_finish;
    logic [WIDTH-1:0] w_sum_next;

    assign w_base = {r_idx, 2'b00};
    assign w_sa   = r_a[w_base +: 4];
    assign w_sb   = r_b[w_base +: 4];
    assign w_ssum = {1'b0, w_sa} + {1'b0, w_sb} + {4'b0000, r_carry};

    // Carry into bit 3 of the slice recovered from the sum bit, used for ovf.
    assign w_c_msb = w_sa[3] ^ w_sb[3] ^ w_ssum[3];

    assign w_g  = w_sa & w_sb;
    assign w_p  = w_sa | w_sb;
    assign w_sg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign w_sp = &w_p;

    assign w_last = (r_idx == c_LAST);

`ifdef NIBBLE_SERIAL_EARLY_DONE_EN
    logic [SLICES-1:0] w_slice_zero;
    logic [SLICES-1:0] w_above;
    logic              w_upper_zero;

    for (genvar i = 0; i < SLICES; i++) begin : g_upper
        assign w_slice_zero[i] = (r_a[4*i +: 4] == 4'h0) && (r_b[4*i +: 4] == 4'h0);
        assign w_above[i]      = (IDX_W'(i) > r_idx);
    end

    // Zero upper slices with no carry leaving this slice cannot change the result.
    assign w_upper_zero = &(w_slice_zero | ~w_above);
    assign w_early      = w_upper_zero && !w_ssum[4] && !w_last;
`else
    assign w_early = 1'b0;
`endif

    assign w_finish = w_last || w_early;

    always_comb begin
        w_sum_next = r_sum;
        w_sum_next[w_base +: 4] = w_ssum[3:0];
`ifdef NIBBLE_SERIAL_EARLY_DONE_EN
        for (int i = 0; i < SLICES; i++) begin
            if (w_early && w_above[i]) begin
                w_sum_next[4*i +: 4] = 4'h0;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b1;
            r_pacc  <= 1'b1;
            r_gacc  <= 1'b0;
            r_pg_n  <= 1'b1;
            r_gg_n  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{sub}};
                        r_carry <= sub | cin;
                        r_idx   <= '0;
                        r_pacc  <= 1'b1;
                        r_gacc  <= 1'b0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_ssum[4];
                    r_pacc  <= r_pacc & w_sp;
                    r_gacc  <= w_sg | (w_sp & r_gacc);
                    if (w_finish) begin
                        r_zero  <= (w_sum_next == '0);
                        r_state <= S_DONE;
                        if (w_early) begin
                            // All-zero upper slices kill both group terms.
                            r_cout <= 1'b0;
                            r_ovf  <= 1'b0;
                            r_pg_n <= 1'b1;
                            r_gg_n <= 1'b1;
                        end else begin
                            r_cout <= w_ssum[4];
                            r_ovf  <= w_c_msb ^ w_ssum[4];
                            r_pg_n <= ~(r_pacc & w_sp);
                            r_gg_n <= ~(w_sg | (w_sp & r_gacc));
                        end
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;
    assign zero = r_zero;
    assign pg_n = r_pg_n;
    assign gg_n = r_gg_n;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// ============================================================================
//  Module   : tb_nibble_serial_adder
//  Brief    : Self-checking bench for nibble_serial_adder (WIDTH=16) with an
//             arithmetic reference model and randomized operations.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder;

    localparam int WIDTH  = 16;
    localparam int SLICES = WIDTH / 4;

    typedef struct packed {
        logic [15:0] s;
        logic        co;
        logic        ov;
        logic        z;
        logic        pn;
        logic        gn;
    } res_t;

    localparam res_t RESET_RES = {16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic        sub   = 1'b0;
    logic        cin   = 1'b0;
    logic [15:0] a     = 16'h0;
    logic [15:0] b     = 16'h0;
    logic        busy, done, cout, ovf, zero, pg_n, gg_n;
    logic [15:0] sum;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
        .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .cout(cout),
        .ovf(ovf), .zero(zero), .pg_n(pg_n), .gg_n(gg_n)
    );

    // Whole-word arithmetic: group generate equals carry out with no carry in.
    function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb,
                                   input logic msub, input logic mcin);
        res_t        r;
        logic [15:0] bb;
        logic [16:0] full;
        logic [16:0] nocin;
        bb    = msub ? ~mb : mb;
        full  = {1'b0, ma} + {1'b0, bb} + {16'h0, (msub ? 1'b1 : mcin)};
        nocin = {1'b0, ma} + {1'b0, bb};
        r.s   = full[15:0];
        r.co  = full[16];
        r.ov  = (ma[15] == bb[15]) && (full[15] != ma[15]);
        r.z   = (full[15:0] == 16'h0);
        r.pn  = ~(&(ma | bb));
        r.gn  = ~nocin[16];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timing model: m_left = edges until done (-1 idle, 0 = done cycle).
    int   m_left  = -1;
    logic m_valid = 1'b1;
    res_t m_pend  = RESET_RES;
    res_t m_exp   = RESET_RES;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left  <= -1;
            m_valid <= 1'b1;
            m_exp   <= RESET_RES;
        end else if (m_left < 0) begin
            if (start) begin
                m_left  <= SLICES;
                m_valid <= 1'b0;
                m_pend  <= model(a, b, sub, cin);
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_exp   <= m_pend;
                m_valid <= 1'b1;
            end
        end else begin
            m_left <= -1;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("busy", {31'b0, busy}, {31'b0, (m_left > 0)});
        chk("done", {31'b0, done}, {31'b0, (m_left == 0)});
        if (m_valid) begin
            chk("sum",  {16'b0, sum},  {16'b0, m_exp.s});
            chk("cout", {31'b0, cout}, {31'b0, m_exp.co});
            chk("ovf",  {31'b0, ovf},  {31'b0, m_exp.ov});
            chk("zero", {31'b0, zero}, {31'b0, m_exp.z});
            chk("pg_n", {31'b0, pg_n}, {31'b0, m_exp.pn});
            chk("gg_n", {31'b0, gg_n}, {31'b0, m_exp.gn});
        end
    end

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb,
                          input logic ts, input logic tc, input logic lit,
                          input logic [15:0] es, input logic eco, input logic eov,
                          input logic ez, input logic egn, input logic poke);
        int n;
        int lat;
        bit got;
        @(negedge clk);
        @(negedge clk);
        a = ta; b = tb; sub = ts; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        if (poke) begin
            @(negedge clk);
            start = 1'b1; a = 16'hAAAA;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done) got = 1'b1;
        end
        chk("done_seen", {31'b0, got}, 32'd1);
        lat = n + (poke ? 2 : 0) + 1;
        if (got) chk("latency", lat, SLICES + 1);
        if (lit && got) begin
            chk("lit_sum",  {16'b0, sum},  {16'b0, es});
            chk("lit_cout", {31'b0, cout}, {31'b0, eco});
            chk("lit_ovf",  {31'b0, ovf},  {31'b0, eov});
            chk("lit_zero", {31'b0, zero}, {31'b0, ez});
            chk("lit_gg_n", {31'b0, gg_n}, {31'b0, egn});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("idle_busy", {31'b0, busy}, 32'd0);
        chk("idle_sum",  {16'b0, sum},  32'd0);
        chk("idle_zero", {31'b0, zero}, 32'd1);

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op(16'h0001, 16'h0002, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op(16'h0F0F, 16'h1111, 1'b0, 1'b1, 1'b1, 16'h2021, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (8) @(negedge clk);

        // Reset in the middle of an operation.
        @(negedge clk);
        a = 16'h1357; b = 16'h2468; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_sum",  {16'b0, sum},  32'd0);
        chk("rst_zero", {31'b0, zero}, 32'd1);
        chk("rst_pg_n", {31'b0, pg_n}, 32'd1);
        chk("rst_gg_n", {31'b0, gg_n}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        run_op(16'h1357, 16'h2468, 1'b0, 1'b0, 1'b1, 16'h37BF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 5))
                0: ra = 16'h0000;
                1: ra = 16'hFFFF;
                2: rb = 16'h0000;
                3: rb = ra;
                default: ;
            endcase
            run_op(ra, rb, 1'($urandom), 1'($urandom), 1'b0, 16'h0, 1'b0, 1'b0,
                   1'b0, 1'b0, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
